isa_loader: RTL and testbench
=============================

# isa_loader

Keyboard-driven instruction loader and CPU launch sequencer for the ISA mode of the lab system. It consumes PS/2 set-2 scan codes, assembles hex-digit keystrokes into 16-bit instruction words, and writes each word into instruction memory on Enter at an auto-incrementing address. On 'r' it reports the program length and pulses the CPU start. It sits between the keyboard receiver and the cpu/instruction memory, and is enabled by the top-level mode FSM while in ISA mode.

## Interface
- ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  high while the mode FSM is in ISA/RUN mode
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
- scan_code  in  8  PS/2 set-2 byte
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  ADDR_W  write address; the next free slot when idle
- mem_wdata  out  16  instruction word being written
- cpu_start  out  1  one-cycle start pulse to the CPU
- prog_len  out  ADDR_W+1  number of words stored, 0..2^ADDR_W
- digits  out  3  hex digits in the current word, 0..4
- full  out  1  memory full; further writes are refused
- err  out  1  one-cycle pulse on a rejected keystroke
- running  out  1  high while in RUN

## Operation
- States: IDLE, COLLECT, BREAK, RUN.
- Reset values: IDLE, all outputs 0, internal word 0, address 0.
- IDLE -> COLLECT when enable=1. This transition clears the word, digits, mem_addr, prog_len and full.
- From any state, enable=0 -> IDLE on the next edge. Stored memory contents are untouched.
- All byte processing happens only on cycles with scan_valid=1.
- Byte 0xE0 (extended prefix) is dropped. The following byte is processed normally, so keypad Enter (E0 5A) acts as Enter.
- Byte 0xF0 in COLLECT -> BREAK. In BREAK, the next byte is discarded, then -> COLLECT. Key releases have no effect.
- Hex keys in COLLECT map as follows: 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46, A=1C, B=32, C=21, D=23, E=24, F=2B.
  - If digits<4: word <= {word[11:0], nibble}, digits+1.
  - If digits==4: the key is ignored and err pulses.
- Backspace 0x66:
  - If digits>0: word <= word>>4, digits-1.
  - Otherwise no effect.
- Enter 0x5A in COLLECT:
  - digits==0: no effect.
  - full=1: err pulses and word/digits are cleared.
  - Otherwise: mem_we=1, mem_wdata=word (right-justified, zero-extended when fewer than 4 digits), and mem_addr holds its current value during the write. On the following edge mem_addr+1, prog_len+1, and word/digits are cleared.
  - When prog_len reaches 2^ADDR_W: full=1 and mem_addr stays at 2^ADDR_W-1. There is no wrap-around.
- 'r' 0x2D in COLLECT:
  - prog_len==0: err pulses and the state stays COLLECT.
  - Otherwise: cpu_start pulses, the state -> RUN, and running=1. Any partial word is discarded.
- RUN ignores all bytes and stays until enable=0.
- Any other code in COLLECT is ignored silently.
- A code arriving in BREAK is always discarded, including 0xF0 and 0xE0.

## Timing
- Outputs are registered. mem_we, cpu_start and err assert on the edge after the scan_valid cycle, for exactly one cycle.
- A write completes in one cycle. The mem_addr increment is visible on the cycle after mem_we.
- Back-to-back scan_valid on consecutive cycles must each be processed. The increment after a write therefore never drops the next byte.
- digits and prog_len update on the edge after the causing scan_valid.
- rst overrides enable and scan_valid. rst asserted mid-write cancels any pending mem_we and cpu_start.
- enable=0 and scan_valid=1 in the same cycle: the byte is discarded and the state -> IDLE.

## Test plan
- Load a word: enable=1, send 1E 16 2B 45 5A -> mem_we pulse with addr 0, wdata 0x21F0; then mem_addr=1, prog_len=1, digits=0.
- Break filtering: send 16 F0 16 1E F0 1E 5A -> wdata 0x0012; the F0-prefixed repeats are ignored.
- Edits and short words: send 16 1E 26 66 5A -> wdata 0x0012. Then send 16 1E 26 25 2E -> err pulse on 2E, digits stays 4. Enter -> wdata 0x1234.
- Extended Enter and empty Enter: 5A with digits=0 -> no write. Then 2B E0 5A -> wdata 0x000F written.
- Full boundary (ADDR_W=2): 4 Enters write addr 0..3 and set full=1. A 5th word+Enter -> err pulse, no mem_we, prog_len=4.
- Run and reset: 'r' with prog_len=0 -> err. After 2 writes, 'r' -> cpu_start for one cycle, running=1, later keys ignored. enable=0 -> IDLE. Re-enable -> prog_len=0, mem_addr=0. rst mid-collect -> all outputs 0.

Source files
------------

// File: rtl/isa_loader.sv
// isa_loader
// Turns PS/2 set-2 scan codes into 16-bit instruction words and writes them
// into instruction memory at consecutive addresses. The 'r' key reports the
// program length and starts the CPU.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   enable         high while the top-level mode FSM is in ISA/RUN mode
//   scan_valid     one-cycle strobe qualifying scan_code
//   scan_code      PS/2 set-2 byte
//   mem_we         one-cycle instruction memory write strobe
//   mem_addr       write address; the next free slot when idle
//   mem_wdata      instruction word being written
//   cpu_start      one-cycle CPU start pulse
//   prog_len       number of stored words, 0..2^ADDR_W
//   digits         hex digits in the current word, 0..4
//   full           memory full; further writes are refused
//   err            one-cycle pulse on a rejected keystroke
//   running        high while in RUN
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | disabled; entering COLLECT clears the program
// COLLECT | assembling hex digits, writing words on Enter
// BREAK   | F0 seen; the next byte (released key) is dropped
// RUN     | CPU launched; all bytes ignored until disabled
module isa_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              scan_valid,
    input  logic [7:0]        scan_code,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_start,
    output logic [ADDR_W:0]   prog_len,
    output logic [2:0]        digits,
    output logic              full,
    output logic              err,
    output logic              running
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_BREAK, S_RUN} state_t;

    localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST = CAP - {{ADDR_W{1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] word;
    // Address advances one cycle after the write so mem_addr is stable
    // while mem_we is high.
    logic        inc_pend;

    // Returns {valid, nibble} for a hex key make code.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        case (c)
            8'h45: return 5'h10;
            8'h16: return 5'h11;
            8'h1E: return 5'h12;
            8'h26: return 5'h13;
            8'h25: return 5'h14;
            8'h2E: return 5'h15;
            8'h36: return 5'h16;
            8'h3D: return 5'h17;
            8'h3E: return 5'h18;
            8'h46: return 5'h19;
            8'h1C: return 5'h1A;
            8'h32: return 5'h1B;
            8'h21: return 5'h1C;
            8'h23: return 5'h1D;
            8'h24: return 5'h1E;
            8'h2B: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    logic [4:0] hex;
    assign hex = hex_decode(scan_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word      <= '0;
            inc_pend  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_start <= 1'b0;
            prog_len  <= '0;
            digits    <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            running   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            err       <= 1'b0;
            inc_pend  <= 1'b0;
            if (inc_pend)
                mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

            if (!enable) begin
                state   <= S_IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state    <= S_COLLECT;
                        word     <= '0;
                        digits   <= '0;
                        mem_addr <= '0;
                        prog_len <= '0;
                        full     <= 1'b0;
                    end
                    S_COLLECT: begin
                        if (scan_valid) begin
                            if (hex[4]) begin
                                if (digits < 3'd4) begin
                                    word   <= {word[11:0], hex[3:0]};
                                    digits <= digits + 3'd1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end else begin
                                case (scan_code)
                                    8'h66: begin
                                        if (digits != 3'd0) begin
                                            word   <= word >> 4;
                                            digits <= digits - 3'd1;
                                        end
                                    end
                                    8'h5A: begin
                                        if (digits != 3'd0) begin
                                            word   <= '0;
                                            digits <= '0;
                                            if (full) begin
                                                err <= 1'b1;
                                            end else begin
                                                mem_we    <= 1'b1;
                                                mem_wdata <= word;
                                                prog_len  <= prog_len + {{ADDR_W{1'b0}}, 1'b1};
                                                // Last slot: saturate at the top address.
                                                full      <= (prog_len == LAST);
                                                inc_pend  <= (prog_len != LAST);
                                            end
                                        end
                                    end
                                    8'h2D: begin
                                        if (prog_len == '0) begin
                                            err <= 1'b1;
                                        end else begin
                                            cpu_start <= 1'b1;
                                            running   <= 1'b1;
                                            state     <= S_RUN;
                                            word      <= '0;
                                            digits    <= '0;
                                        end
                                    end
                                    8'hF0:   state <= S_BREAK;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    S_BREAK: begin
                        if (scan_valid)
                            state <= S_COLLECT;
                    end
                    S_RUN: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isa_loader.sv
module tb_isa_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          scan_valid;
    logic [7:0]    scan_code;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_start;
    logic [AW:0]   prog_len;
    logic [2:0]    digits;
    logic          full;
    logic          err;
    logic          running;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;

    logic          last_we, last_err, last_start;
    logic [AW-1:0] last_addr;
    logic [15:0]   last_wdata;

    isa_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .scan_valid(scan_valid), .scan_code(scan_code),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_start(cpu_start), .prog_len(prog_len), .digits(digits),
        .full(full), .err(err), .running(running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) we_count++;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte for one cycle and captures the pulses it caused.
    // Consecutive calls drive bytes on consecutive cycles.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        last_we    = mem_we;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_err   = err;
        last_start = cpu_start;
    endtask

    task automatic start_collect();
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        n_checks++; if (prog_len !== 3'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", prog_len); end
        n_checks++; if ({cpu_start, full, err, running, digits} !== 7'd0) begin n_fail++; $display("FAIL reset_misc: got %b want 0", {cpu_start, full, err, running, digits}); end
        n_checks++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
    endtask

    task automatic test_load();
        start_collect();
        send(8'h1E); send(8'h16); send(8'h2B); send(8'h45);
        n_checks++; if (digits !== 3'd4) begin n_fail++; $display("FAIL load_digits: got %0d want 4", digits); end
        send(8'h5A);
        n_checks++; if (last_we !== 1'b1) begin n_fail++; $display("FAIL load_we: got %b want 1", last_we); end
        n_checks++; if (last_addr !== 2'd0) begin n_fail++; $display("FAIL load_addr: got %0d want 0", last_addr); end
        n_checks++; if (last_wdata !== 16'h21F0) begin n_fail++; $display("FAIL load_wdata: got %h want 21f0", last_wdata); end
        idle(1);
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load_we_width: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 2'd1) begin n_fail++; $display("FAIL load_addr_inc: got %0d want 1", mem_addr); end
        n_checks++; if (prog_len !== 3'd1) begin n_fail++; $display("FAIL load_len: got %0d want 1", prog_len); end
        n_checks++; if (digits !== 3'd0) begin n_fail++; $display("FAIL load_digits_clr: got %0d want 0", digits); end
    endtask

    task automatic test_break();
        start_collect();
        send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E); send(8'h5A);
        n_checks++; if (last_we !== 1'b1) begin n_fail++; $display("FAIL break_we: got %b want 1", last_we); end
        n_checks++; if (last_wdata !== 16'h0012) begin n_fail++; $display("FAIL break_wdata: got %h want 0012", last_wdata); end
        n_checks++; if (last_addr !== 2'd0) begin n_fail++; $display("FAIL break_addr: got %0d want 0", last_addr); end
    endtask

    task automatic test_edit();
        start_collect();
        send(8'h16); send(8'h1E); send(8'h26); send(8'h66); send(8'h5A);
        n_checks++; if (last_wdata !== 16'h0012 || last_we !== 1'b1) begin n_fail++; $display("FAIL edit_bs_wdata: got %h we %b want 0012 we 1", last_wdata, last_we); end
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        n_checks++; if (last_err !== 1'b0) begin n_fail++; $display("FAIL edit_no_err: got %b want 0", last_err); end
        send(8'h2E);
        n_checks++; if (last_err !== 1'b1) begin n_fail++; $display("FAIL edit_err5: got %b want 1", last_err); end
        n_checks++; if (digits !== 3'd4) begin n_fail++; $display("FAIL edit_digits4: got %0d want 4", digits); end
        idle(1);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL edit_err_width: got %b want 0", err); end
        send(8'h5A);
        n_checks++; if (last_wdata !== 16'h1234) begin n_fail++; $display("FAIL edit_wdata: got %h want 1234", last_wdata); end
        n_checks++; if (last_addr !== 2'd1) begin n_fail++; $display("FAIL edit_addr: got %0d want 1", last_addr); end
    endtask

    task automatic test_ext();
        start_collect();
        send(8'h5A);
        n_checks++; if (last_we !== 1'b0 || last_err !== 1'b0) begin n_fail++; $display("FAIL ext_empty: got we %b err %b want 0 0", last_we, last_err); end
        n_checks++; if (prog_len !== 3'd0) begin n_fail++; $display("FAIL ext_empty_len: got %0d want 0", prog_len); end
        send(8'h2B); send(8'hE0); send(8'h5A);
        n_checks++; if (last_we !== 1'b1 || last_wdata !== 16'h000F) begin n_fail++; $display("FAIL ext_enter: got we %b wdata %h want 1 000f", last_we, last_wdata); end
    endtask

    task automatic test_full();
        logic [7:0] codes [4];
        int wc;
        codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25;
        start_collect();
        for (int i = 0; i < 4; i++) begin
            send(codes[i]); send(8'h5A);
            n_checks++;
            if (last_we !== 1'b1 || last_addr !== 2'(i) || last_wdata !== 16'(i + 1)) begin
                n_fail++; $display("FAIL full_write%0d: got we %b addr %0d wdata %h want 1 %0d %h", i, last_we, last_addr, last_wdata, i, 16'(i + 1));
            end
        end
        idle(1);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_checks++; if (prog_len !== 3'd4) begin n_fail++; $display("FAIL full_len: got %0d want 4", prog_len); end
        n_checks++; if (mem_addr !== 2'd3) begin n_fail++; $display("FAIL full_addr_sat: got %0d want 3", mem_addr); end
        wc = we_count;
        send(8'h2E); send(8'h5A);
        n_checks++; if (last_err !== 1'b1 || last_we !== 1'b0) begin n_fail++; $display("FAIL full_reject: got err %b we %b want 1 0", last_err, last_we); end
        idle(2);
        n_checks++; if (we_count !== wc) begin n_fail++; $display("FAIL full_no_write: got %0d writes want %0d", we_count, wc); end
        n_checks++; if (prog_len !== 3'd4 || digits !== 3'd0) begin n_fail++; $display("FAIL full_after: got len %0d digits %0d want 4 0", prog_len, digits); end
    endtask

    task automatic test_run();
        start_collect();
        send(8'h2D);
        n_checks++; if (last_err !== 1'b1 || last_start !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL run_empty: got err %b start %b run %b want 1 0 0", last_err, last_start, running); end
        send(8'h16); send(8'h5A); send(8'h1E); send(8'h5A); send(8'h26); send(8'h2D);
        n_checks++; if (last_start !== 1'b1 || running !== 1'b1) begin n_fail++; $display("FAIL run_start: got start %b run %b want 1 1", last_start, running); end
        idle(1);
        n_checks++; if (cpu_start !== 1'b0) begin n_fail++; $display("FAIL run_start_width: got %b want 0", cpu_start); end
        n_checks++; if (digits !== 3'd0 || prog_len !== 3'd2) begin n_fail++; $display("FAIL run_state: got digits %0d len %0d want 0 2", digits, prog_len); end
        send(8'h16); send(8'h5A); send(8'h2D);
        n_checks++; if (last_start !== 1'b0 || digits !== 3'd0 || we_count < 0) begin n_fail++; $display("FAIL run_ignore_start: got start %b digits %0d want 0 0", last_start, digits); end
        n_checks++; if (prog_len !== 3'd2 || last_we !== 1'b0) begin n_fail++; $display("FAIL run_ignore_write: got len %0d we %b want 2 0", prog_len, last_we); end
        enable = 1'b0;
        idle(1);
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL run_disable: got %b want 0", running); end
        n_checks++; if (prog_len !== 3'd2) begin n_fail++; $display("FAIL run_idle_len: got %0d want 2", prog_len); end
        enable = 1'b1;
        idle(1);
        n_checks++; if (prog_len !== 3'd0 || mem_addr !== 2'd0 || full !== 1'b0) begin n_fail++; $display("FAIL run_reenable: got len %0d addr %0d full %b want 0 0 0", prog_len, mem_addr, full); end
    endtask

    task automatic test_rst();
        start_collect();
        send(8'h16); send(8'h1E);
        n_checks++; if (digits !== 3'd2) begin n_fail++; $display("FAIL rst_pre_digits: got %0d want 2", digits); end
        rst        = 1'b1;
        scan_valid = 1'b1;
        scan_code  = 8'h5A;
        idle(1);
        scan_valid = 1'b0;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_we: got %b want 0", mem_we); end
        n_checks++; if (digits !== 3'd0 || prog_len !== 3'd0 || mem_addr !== 2'd0 || running !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: got digits %0d len %0d addr %0d run %b want 0", digits, prog_len, mem_addr, running); end
        rst = 1'b0;
        idle(2);
        send(8'h26); send(8'h5A);
        n_checks++; if (last_we !== 1'b1 || last_wdata !== 16'h0003 || last_addr !== 2'd0) begin n_fail++; $display("FAIL rst_recover: got we %b wdata %h addr %0d want 1 0003 0", last_we, last_wdata, last_addr); end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        idle(3);
        test_reset();
        rst = 1'b0;
        idle(1);
        test_load();
        test_break();
        test_edit();
        test_ext();
        test_full();
        test_run();
        test_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
